// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the instruction fetch queue
package riscv_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         IFQ_LANE_BIT  = 2;

    // Fields sized for the widest configuration; narrower builds use the low bits.
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        err;
    } ifq_entry_t;

    typedef struct packed {
        logic [63:0] pc;
        logic        stale;
    } ifq_tag_t;

    typedef enum logic {
        AR_IDLE,
        AR_REQ
    } ifq_ar_state_t;

endpackage

// File: rtl/riscv_ifq_fifo.sv
// rtl/riscv_ifq_fifo.sv - generic synchronous FIFO with clear, registered head
module riscv_ifq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));

endmodule

// File: rtl/riscv_if_fetch_queue.sv
// rtl/riscv_if_fetch_queue.sv - PC-to-decode fetch queue over AXI-Lite reads; RISCV_IFQ_BYPASS_EN enables same-cycle forwarding
module riscv_if_fetch_queue
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int MAX_OUTST   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   i_read_instr,
    input  logic [DATA_WIDTH-1:0]  i_pc,
    input  logic                   i_flush,
    output logic                   o_stall,
    output logic [ADDR_WIDTH-1:0]  o_araddr,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    input  logic [DATA_WIDTH-1:0]  i_rdata,
    input  logic [1:0]             i_rresp,
    input  logic                   i_rvalid,
    output logic                   o_rready,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0]  o_instr_pc,
    output logic                   o_instr_err,
    input  logic                   i_instr_ready
);
    localparam int QCW = $clog2(DEPTH) + 1;
    localparam int TCW = $clog2(MAX_OUTST) + 1;
    localparam int CW  = QCW + 1;

    ifq_ar_state_t  ar_state;
    logic           rready_q;
    logic           accept;
    logic           r_hs;
    logic           deliver;
    logic [CW-1:0]  credit;

    ifq_tag_t       tag_in, tag_head;
    logic           tag_pop, tag_full, tag_empty, tag_stale;
    logic [TCW-1:0] tag_count, stale_cnt;

    ifq_entry_t     q_in, q_head;
    logic           q_push, q_pop, q_full, q_empty;
    logic [QCW-1:0] q_count;
    logic [31:0]    lane_instr;

    assign credit  = CW'(q_count) + CW'(tag_count);
    // q_full implies credit >= DEPTH; it only keeps the queue guard explicit.
    assign o_stall = enable & ((ar_state == AR_REQ) | (credit >= CW'(DEPTH)) | tag_full | q_full);
    assign accept  = i_read_instr & enable & ~o_stall & ~i_flush & (ar_state == AR_IDLE);
    assign o_rready = rready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_state  <= AR_IDLE;
            o_arvalid <= 1'b0;
            o_araddr  <= '0;
            rready_q  <= 1'b0;
        end else begin
            rready_q <= 1'b1;
            case (ar_state)
                AR_IDLE: if (accept) begin
                    o_araddr  <= ADDR_WIDTH'(i_pc);
                    o_arvalid <= 1'b1;
                    ar_state  <= AR_REQ;
                end
                AR_REQ: if (i_arready) begin
                    o_arvalid <= 1'b0;
                    ar_state  <= AR_IDLE;
                end
                default: ar_state <= AR_IDLE;
            endcase
        end
    end

    assign tag_in  = '{pc: 64'(i_pc), stale: 1'b0};
    assign r_hs    = i_rvalid & rready_q;
    assign tag_pop = r_hs & ~tag_empty;

    // Tags are in order, so everything outstanding at a flush is the oldest stale_cnt entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            stale_cnt <= '0;
        end else if (i_flush) begin
            stale_cnt <= tag_count - TCW'(tag_pop);
        end else if (tag_pop && stale_cnt != '0) begin
            stale_cnt <= stale_cnt - 1'b1;
        end
    end

    assign tag_stale  = tag_head.stale | (stale_cnt != '0);
    assign lane_instr = (DATA_WIDTH == 64 && tag_head.pc[IFQ_LANE_BIT])
                        ? i_rdata[DATA_WIDTH-1 -: 32] : i_rdata[31:0];
    assign q_in       = '{instr: lane_instr, pc: tag_head.pc, err: (i_rresp != AXI_RESP_OKAY)};
    assign deliver    = tag_pop & ~tag_stale & ~i_flush;
    assign q_pop      = ~q_empty & i_instr_ready;

`ifdef RISCV_IFQ_BYPASS_EN
    logic bypass;
    assign bypass        = deliver & q_empty & i_instr_ready;
    assign q_push        = deliver & ~bypass;
    assign o_instr_valid = ~q_empty | bypass;
    assign o_instr       = bypass ? q_in.instr[INSTR_WIDTH-1:0] : q_head.instr[INSTR_WIDTH-1:0];
    assign o_instr_pc    = bypass ? q_in.pc[DATA_WIDTH-1:0]     : q_head.pc[DATA_WIDTH-1:0];
    assign o_instr_err   = bypass ? q_in.err                    : q_head.err;
`else
    assign q_push        = deliver;
    assign o_instr_valid = ~q_empty;
    assign o_instr       = q_head.instr[INSTR_WIDTH-1:0];
    assign o_instr_pc    = q_head.pc[DATA_WIDTH-1:0];
    assign o_instr_err   = q_head.err;
`endif

    riscv_ifq_fifo #(.WIDTH($bits(ifq_tag_t)), .DEPTH(MAX_OUTST)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .push  (accept),
        .pop   (tag_pop),
        .wdata (tag_in),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    riscv_ifq_fifo #(.WIDTH($bits(ifq_entry_t)), .DEPTH(DEPTH)) u_out_q (
        .clk   (clk),
        .reset (reset),
        .clear (i_flush),
        .push  (q_push),
        .pop   (q_pop),
        .wdata (q_in),
        .rdata (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

endmodule

// File: tb/tb_riscv_if_fetch_queue.sv
// tb/tb_riscv_if_fetch_queue.sv - directed self-checking bench for riscv_if_fetch_queue
module tb_riscv_if_fetch_queue;

    logic        clk = 1'b0;
    logic        reset, enable, i_read_instr, i_flush, i_arready, i_rvalid, i_instr_ready;
    logic [63:0] i_pc, i_rdata;
    logic [1:0]  i_rresp;
    logic        o_stall, o_arvalid, o_rready, o_instr_valid, o_instr_err;
    logic [63:0] o_araddr, o_instr_pc;
    logic [31:0] o_instr;

    int n_cmp = 0;
    int n_err = 0;

    riscv_if_fetch_queue dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .i_read_instr  (i_read_instr),
        .i_pc          (i_pc),
        .i_flush       (i_flush),
        .o_stall       (o_stall),
        .o_araddr      (o_araddr),
        .o_arvalid     (o_arvalid),
        .i_arready     (i_arready),
        .i_rdata       (i_rdata),
        .i_rresp       (i_rresp),
        .i_rvalid      (i_rvalid),
        .o_rready      (o_rready),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_instr_err   (o_instr_err),
        .i_instr_ready (i_instr_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [31:0] p);
        return {32'hB000_0000 | p, 32'hA000_0000 | p};
    endfunction

    task automatic fetch(input logic [63:0] pc);
        i_read_instr = 1'b1;
        i_pc = pc;
        cyc();
        i_read_instr = 1'b0;
        i_arready = 1'b1;
        cyc();
        i_arready = 1'b0;
    endtask

    task automatic resp(input logic [63:0] data, input logic [1:0] rr);
        i_rvalid = 1'b1;
        i_rdata = data;
        i_rresp = rr;
        cyc();
        i_rvalid = 1'b0;
    endtask

    // Response delivered with decode ready: same cycle with bypass, next cycle otherwise.
    task automatic resp_chk(input string tag, input logic [63:0] data, input logic [1:0] rr,
                            input logic [31:0] ei, input logic [63:0] epc, input logic eerr);
        i_rvalid = 1'b1;
        i_rdata = data;
        i_rresp = rr;
`ifdef RISCV_IFQ_BYPASS_EN
        #1;
        chk({tag, "_valid"}, 64'(o_instr_valid), 64'd1);
        chk({tag, "_instr"}, 64'(o_instr), 64'(ei));
        chk({tag, "_pc"}, o_instr_pc, epc);
        chk({tag, "_err"}, 64'(o_instr_err), 64'(eerr));
        cyc();
        i_rvalid = 1'b0;
`else
        cyc();
        i_rvalid = 1'b0;
        chk({tag, "_valid"}, 64'(o_instr_valid), 64'd1);
        chk({tag, "_instr"}, 64'(o_instr), 64'(ei));
        chk({tag, "_pc"}, o_instr_pc, epc);
        chk({tag, "_err"}, 64'(o_instr_err), 64'(eerr));
`endif
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; i_read_instr = 1'b0; i_flush = 1'b0;
        i_arready = 1'b0; i_rvalid = 1'b0; i_instr_ready = 1'b1;
        i_pc = '0; i_rdata = '0; i_rresp = 2'b00;
        cyc();
        cyc();

        // reset state
        chk("rst_arvalid", 64'(o_arvalid), 64'd0);
        chk("rst_araddr", o_araddr, 64'd0);
        chk("rst_rready", 64'(o_rready), 64'd0);
        chk("rst_valid", 64'(o_instr_valid), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        chk("rst_pc", o_instr_pc, 64'd0);
        chk("rst_stall", 64'(o_stall), 64'd0);
        reset = 1'b0;
        cyc();
        chk("rready_up", 64'(o_rready), 64'd1);

        // single fetch, upper lane
        i_read_instr = 1'b1;
        i_pc = 64'h1004;
        cyc();
        i_read_instr = 1'b0;
        chk("sf_arvalid", 64'(o_arvalid), 64'd1);
        chk("sf_araddr", o_araddr, 64'h1004);
        chk("sf_stall", 64'(o_stall), 64'd1);
        i_arready = 1'b1;
        cyc();
        i_arready = 1'b0;
        chk("sf_arvalid_drop", 64'(o_arvalid), 64'd0);
        resp_chk("sf", 64'hAAAA_BBBB_1111_2222, 2'b00, 32'hAAAABBBB, 64'h1004, 1'b0);
        cyc();
        chk("sf_drained", 64'(o_instr_valid), 64'd0);

        // backpressure: four fetches fill the credit
        i_instr_ready = 1'b0;
        fetch(64'h0);  resp(mk(32'h0), 2'b00);
        fetch(64'h4);  resp(mk(32'h4), 2'b00);
        fetch(64'h8);  resp(mk(32'h8), 2'b00);
        chk("bp_stall_3", 64'(o_stall), 64'd0);
        fetch(64'hC);  resp(mk(32'hC), 2'b00);
        chk("bp_stall_4", 64'(o_stall), 64'd1);
        cyc();
        cyc();
        chk("bp_hold_valid", 64'(o_instr_valid), 64'd1);
        chk("bp_hold_pc", o_instr_pc, 64'h0);
        chk("bp_hold_instr", 64'(o_instr), 64'hA000_0000);
        i_instr_ready = 1'b1;
        cyc();
        chk("bp_d1_pc", o_instr_pc, 64'h4);
        chk("bp_d1_instr", 64'(o_instr), 64'hB000_0004);
        cyc();
        chk("bp_d2_pc", o_instr_pc, 64'h8);
        chk("bp_d2_instr", 64'(o_instr), 64'hA000_0008);
        cyc();
        chk("bp_d3_pc", o_instr_pc, 64'hC);
        chk("bp_d3_instr", 64'(o_instr), 64'hB000_000C);
        chk("bp_stall_low", 64'(o_stall), 64'd0);
        cyc();
        chk("bp_empty", 64'(o_instr_valid), 64'd0);

        // flush with two outstanding
        fetch(64'h20);
        fetch(64'h24);
        chk("fl_stall_outst", 64'(o_stall), 64'd1);
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        resp(mk(32'h20), 2'b00);
        chk("fl_drop1", 64'(o_instr_valid), 64'd0);
        resp(mk(32'h24), 2'b00);
        chk("fl_drop2", 64'(o_instr_valid), 64'd0);
        chk("fl_stall_free", 64'(o_stall), 64'd0);
        fetch(64'h100);
        resp_chk("fl_next", mk(32'h100), 2'b00, 32'hA000_0100, 64'h100, 1'b0);
        cyc();

        // AR hold with a flush mid-wait
        i_read_instr = 1'b1;
        i_pc = 64'h200;
        cyc();
        i_read_instr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("arh_arvalid", 64'(o_arvalid), 64'd1);
            chk("arh_araddr", o_araddr, 64'h200);
            chk("arh_stall", 64'(o_stall), 64'd1);
            i_flush = (k == 2);
            cyc();
        end
        i_flush = 1'b0;
        i_arready = 1'b1;
        cyc();
        i_arready = 1'b0;
        chk("arh_done", 64'(o_arvalid), 64'd0);
        resp(mk(32'h200), 2'b00);
        chk("arh_stale_drop", 64'(o_instr_valid), 64'd0);

        // bus error
        fetch(64'h40);
        resp_chk("berr", mk(32'h40), 2'b10, 32'hA000_0040, 64'h40, 1'b1);
        cyc();

        // reset with three queued entries
        i_instr_ready = 1'b0;
        fetch(64'h50); resp(mk(32'h50), 2'b00);
        fetch(64'h54); resp(mk(32'h54), 2'b00);
        fetch(64'h58); resp(mk(32'h58), 2'b00);
        chk("mr_queued", 64'(o_instr_valid), 64'd1);
        reset = 1'b1;
        cyc();
        chk("mr_valid", 64'(o_instr_valid), 64'd0);
        chk("mr_instr", 64'(o_instr), 64'd0);
        chk("mr_pc", o_instr_pc, 64'd0);
        chk("mr_err", 64'(o_instr_err), 64'd0);
        chk("mr_stall", 64'(o_stall), 64'd0);
        chk("mr_arvalid", 64'(o_arvalid), 64'd0);
        chk("mr_rready", 64'(o_rready), 64'd0);
        reset = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
